regblock_host: RTL and testbench

//   Host-side initiator for the two-entry enable-register block. Accepts single read/write

---
 rtl/regblock_host.sv | 141 ++++++++++++++
 tb/tb_regblock_host.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regblock_host.sv
// Host-side initiator for a small enable-register block: one request/response at a time,
// translating valid/ready requests into the block's write port and registered read port.
module regblock_host #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 2,
  parameter int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rb_en,
  output logic [IDX_W-1:0]  rb_wr_index,
  output logic [DATA_W-1:0] rb_d,
  output logic [IDX_W-1:0]  rb_rd_index,
  input  logic [DATA_W-1:0] rb_q,
  output logic [2:0]        state_dbg
);

  // Handshakes: a request transfers on the rising edge where req_valid && req_ready,
  // a response on the rising edge where rsp_valid && rsp_ready; neither side may retract
  // valid or change its payload while waiting.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [IDX_W:0] NREGS_C = (IDX_W+1)'(NREGS);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rb_en_q, rb_en_d;
  logic [IDX_W-1:0]    rb_wr_index_q, rb_wr_index_d;
  logic [DATA_W-1:0]   rb_d_q, rb_d_d;
  logic [IDX_W-1:0]    rb_rd_index_q, rb_rd_index_d;
  logic                accept;
  logic                idx_oor;

  assign accept  = req_valid && req_ready_q;
  assign idx_oor = ({1'b0, req_idx} >= NREGS_C);

  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rb_wr_index_d = rb_wr_index_q;
    rb_d_d        = rb_d_q;
    rb_rd_index_d = rb_rd_index_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (idx_oor) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we) begin
            state_d       = WRITE;
            rb_wr_index_d = req_idx;
            rb_d_d        = req_wdata;
          end else begin
            state_d       = RD_ADDR;
            rb_rd_index_d = req_idx;
          end
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        // The register block has registered rb_rd_index, so rb_q is valid now.
        state_d     = RESP;
        rsp_rdata_d = rb_q;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of what the next state implies.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rb_en_d     = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rb_en_q       <= 1'b0;
      rb_wr_index_q <= '0;
      rb_d_q        <= '0;
      rb_rd_index_q <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rb_en_q       <= rb_en_d;
      rb_wr_index_q <= rb_wr_index_d;
      rb_d_q        <= rb_d_d;
      rb_rd_index_q <= rb_rd_index_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rb_en       = rb_en_q;
  assign rb_wr_index = rb_wr_index_q;
  assign rb_d        = rb_d_q;
  assign rb_rd_index = rb_rd_index_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_regblock_host.sv
// Bench for regblock_host: a 2-entry instance against a behavioural register block,
// plus a 3-entry instance for the out-of-range path.
module tb_regblock_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 2-entry instance
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [0:0]  req_idx = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, rb_en;
  logic [31:0] rsp_rdata, rb_d, rb_q;
  logic [0:0]  rb_wr_index, rb_rd_index;
  logic [2:0]  state_dbg;

  // 3-entry instance
  logic        req3_valid = 1'b0, req3_we = 1'b0, rsp3_ready = 1'b1;
  logic [1:0]  req3_idx = '0;
  logic [31:0] req3_wdata = '0;
  logic        req3_ready, rsp3_valid, rsp3_err, rb3_en;
  logic [31:0] rsp3_rdata, rb3_d;
  logic [31:0] rb3_q = 32'hA5A5_A5A5;
  logic [1:0]  rb3_wr_index, rb3_rd_index;
  logic [2:0]  state3_dbg;

  int n_checks = 0, n_fail = 0;
  int n_acc = 0, n_rsp = 0, n_rb_en = 0, n_rb3_en = 0;
  logic [0:0]  last_en_idx;
  logic [31:0] last_en_d;
  logic [31:0] exp_q[$];
  logic [31:0] model_regs[2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regblock_host #(.DATA_W(32), .NREGS(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rb_en(rb_en), .rb_wr_index(rb_wr_index), .rb_d(rb_d),
    .rb_rd_index(rb_rd_index), .rb_q(rb_q), .state_dbg(state_dbg)
  );

  regblock_host #(.DATA_W(32), .NREGS(3), .IDX_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req3_valid), .req_ready(req3_ready), .req_we(req3_we),
    .req_idx(req3_idx), .req_wdata(req3_wdata),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_rdata(rsp3_rdata), .rsp_err(rsp3_err),
    .rb_en(rb3_en), .rb_wr_index(rb3_wr_index), .rb_d(rb3_d),
    .rb_rd_index(rb3_rd_index), .rb_q(rb3_q), .state_dbg(state3_dbg)
  );

  // Behavioural register block: write on rb_en, read index registered, q one cycle later.
  logic [31:0] rb_mem[2];
  logic [0:0]  rb_rd_idx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_mem[0]   <= '0;
      rb_mem[1]   <= '0;
      rb_rd_idx_q <= '0;
    end else begin
      if (rb_en) rb_mem[rb_wr_index] <= rb_d;
      rb_rd_idx_q <= rb_rd_index;
    end
  end
  assign rb_q = rb_mem[rb_rd_idx_q];

  // Inputs change 1ns after posedge, so negedge sees a settled picture of the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) n_acc++;
      if (rsp_valid && rsp_ready) n_rsp++;
      if (rb_en) begin
        n_rb_en++;
        last_en_idx = rb_wr_index;
        last_en_d   = rb_d;
      end
      if (rb3_en) n_rb3_en++;
    end
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request, returns the response and the accept-to-rsp_valid latency in cycles.
  // Ends at the negedge just before the response handshake edge.
  task automatic do_req(input logic we, input logic [0:0] idx, input logic [31:0] wd,
                        input int hold, output int lat, output logic [31:0] rd,
                        output logic err, output int waits);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_idx = idx; req_wdata = wd;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    rsp_ready = (hold == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check("rsp_arrive", {31'b0, rsp_valid}, 32'd1);
    rd  = rsp_rdata;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  int          lat, waits, acc0, rsp0, en0;
  logic [31:0] rd;
  logic        err;
  logic [1:0]  idx3_before;

  initial begin
    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rb_en",     {31'b0, rb_en}, 32'd0);
    check("rst_rb_d",      rb_d, 32'd0);
    check("rst_indices",   {30'b0, rb_wr_index, rb_rd_index}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // ---- read idx0 after reset ----
    do_req(1'b0, 1'b0, 32'h0, 0, lat, rd, err, waits);
    check("rd0_reset_data", rd, 32'h0);
    check("rd0_reset_lat", lat, 32'd3);

    // ---- write idx0 ----
    en0 = n_rb_en;
    do_req(1'b1, 1'b0, 32'hDEAD_BEEF, 0, lat, rd, err, waits);
    check("wr0_lat", lat, 32'd2);
    check("wr0_err", {31'b0, err}, 32'd0);
    check("wr0_rdata", rd, 32'd0);
    check("wr0_en_cycles", n_rb_en - en0, 32'd1);
    check("wr0_en_idx", {31'b0, last_en_idx}, 32'd0);
    check("wr0_en_d", last_en_d, 32'hDEAD_BEEF);

    // ---- write idx1 then read it back-to-back ----
    do_req(1'b1, 1'b1, 32'h1234_5678, 0, lat, rd, err, waits);
    check("wr1_lat", lat, 32'd2);
    do_req(1'b0, 1'b1, 32'h0, 0, lat, rd, err, waits);
    check("rd1_data", rd, 32'h1234_5678);
    check("rd1_lat", lat, 32'd3);
    check("b2b_no_wait", waits, 32'd0);
    check("rd1_rb_rd_index", {31'b0, rb_rd_index}, 32'd1);
    do_req(1'b0, 1'b0, 32'h0, 0, lat, rd, err, waits);
    check("rd0_data", rd, 32'hDEAD_BEEF);

    // ---- response back-pressure ----
    acc0 = n_acc;
    do_req(1'b0, 1'b1, 32'h0, 5, lat, rd, err, waits);
    check("bp_rdata", rd, 32'h1234_5678);
    @(posedge clk); #1;
    check("bp_one_accept", n_acc - acc0, 32'd1);

    // ---- out-of-range on the 3-entry instance ----
    idx3_before = rb3_rd_index;
    @(posedge clk); #1;
    req3_valid = 1'b1; req3_we = 1'b0; req3_idx = 2'd3;
    @(negedge clk);
    check("oor_accept", {31'b0, req3_ready}, 32'd1);
    @(posedge clk); #1;
    req3_valid = 1'b0;
    @(negedge clk);
    check("oor_lat1_valid", {31'b0, rsp3_valid}, 32'd1);
    check("oor_err", {31'b0, rsp3_err}, 32'd1);
    check("oor_rdata", rsp3_rdata, 32'd0);
    check("oor_rd_index", {30'b0, rb3_rd_index}, {30'b0, idx3_before});
    @(posedge clk); #1;
    req3_valid = 1'b1; req3_we = 1'b1; req3_idx = 2'd3; req3_wdata = 32'h5555_AAAA;
    @(negedge clk);
    @(posedge clk); #1;
    req3_valid = 1'b0;
    @(negedge clk);
    check("oor_wr_err", {31'b0, rsp3_err}, 32'd1);
    check("oor_wr_index", {30'b0, rb3_wr_index}, 32'd0);
    repeat (2) @(negedge clk);
    check("oor_rsp_cleared", {30'b0, rsp3_valid, rsp3_err}, 32'd0);
    check("oor_no_rb_en", n_rb3_en, 32'd0);

    // ---- reset during WRITE ----
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_idx = 1'b1; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst_mid_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_en_before", {31'b0, rb_en}, 32'd1);
    rsp0 = n_rsp;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_en_drop", {31'b0, rb_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_rsp_count", n_rsp - rsp0, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);

    // ---- random stream against a 2-entry model ----
    model_regs[0] = '0;
    model_regs[1] = '0;
    acc0 = n_acc;
    rsp0 = n_rsp;
    for (int i = 0; i < 200; i++) begin
      logic        r_we;
      logic [0:0]  r_idx;
      logic [31:0] r_wd;
      int          r_hold;
      r_we   = 1'($urandom_range(0, 1));
      r_idx  = 1'($urandom_range(0, 1));
      r_wd   = $urandom;
      r_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      exp_q.push_back(r_we ? 32'd0 : model_regs[r_idx]);
      if (r_we) model_regs[r_idx] = r_wd;
      do_req(r_we, r_idx, r_wd, r_hold, lat, rd, err, waits);
      check("rnd_rdata", rd, exp_q.pop_front());
      check("rnd_err", {31'b0, err}, 32'd0);
      check("rnd_lat", lat, r_we ? 32'd2 : 32'd3);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("rnd_accepts", n_acc - acc0, 32'd200);
    check("rnd_responses", n_rsp - rsp0, 32'd200);
    check("rnd_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
